// File: rtl/disk2_ctrl.sv
// disk2_ctrl
//
// Soft-switch decoder and mechanics model for a Disk II style floppy
// controller. Each CPU access to the $C0E0-$C0EF window arrives as a
// one-cycle io_sel strobe with the low address nibble. The block latches
// the four stepper phase magnets, the motor on/off state (the spindle keeps
// turning for MOTOR_OFF_CYCLES after a motor-off access), the drive select
// and the Q6/Q7 mode latches. It also tracks the head position in
// half-tracks by sampling the phase magnets once every STEP_CYCLES while
// the spindle runs.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   io_sel      one-cycle strobe per access to the soft-switch window
//   addr        A[3:0] of that access (switch = addr[3:1], value = addr[0])
//   phs         stepper phase magnet latches, bit n is phase n
//   d1_active   drive 1 spindle running
//   d2_active   drive 2 spindle running
//   q6, q7      mode latches
//   half_track  head position in half-tracks, 0..68
//   track       half_track >> 1
//   step        one-cycle pulse whenever the head actually moves
//   bump        one-cycle pulse when a move is blocked at the end stops

module disk2_ctrl #(
    parameter int MOTOR_OFF_CYCLES = 14318180,
    parameter int STEP_CYCLES      = 14318
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       io_sel,
    input  logic [3:0] addr,
    output logic [3:0] phs,
    output logic       d1_active,
    output logic       d2_active,
    output logic       q6,
    output logic       q7,
    output logic [6:0] half_track,
    output logic [5:0] track,
    output logic       step,
    output logic       bump
);

    localparam int CNT_W  = (MOTOR_OFF_CYCLES > 1) ? $clog2(MOTOR_OFF_CYCLES) : 1;
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  OFF_LOAD  = CNT_W'(MOTOR_OFF_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [6:0]        H_MAX     = 7'd68;

    typedef enum logic [1:0] {
        MOVE_HOLD,
        MOVE_UP,
        MOVE_DOWN
    } move_e;

    logic [3:0]        phs_q,       phs_d;
    logic              motorOn_q,   motorOn_d;
    logic              countRun_q,  countRun_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic              driveSel_q,  driveSel_d;
    logic              q6_q,        q6_d;
    logic              q7_q,        q7_d;
    logic [STEP_W-1:0] stepCnt_q,   stepCnt_d;
    logic [6:0]        halfTrack_q, halfTrack_d;
    logic              step_q,      step_d;
    logic              bump_q,      bump_d;

    logic [2:0] sw;
    logic       val;
    logic       stepTick;
    logic [1:0] basePhase;
    logic [1:0] nextPhase;
    logic [1:0] prevPhase;
    move_e      move;

    assign sw  = addr[3:1];
    assign val = addr[0];

    assign stepTick = motorOn_q && (stepCnt_q == STEP_LAST);

    // For an even position the head sits on phase (h>>1)&3. For an odd
    // position it straddles (h-1)>>1 and the one above it; since h is odd,
    // (h-1)>>1 equals h>>1, so both cases share the same base phase.
    // The phase register sampled here is the value from before any
    // same-cycle access, because it is the registered copy.
    always_comb begin
        basePhase = halfTrack_q[2:1];
        nextPhase = basePhase + 2'd1;
        prevPhase = basePhase - 2'd1;
        move      = MOVE_HOLD;
        if (!halfTrack_q[0]) begin
            if (phs_q[basePhase]) begin
                move = MOVE_HOLD;
            end else if (phs_q[nextPhase]) begin
                move = MOVE_UP;
            end else if (phs_q[prevPhase]) begin
                move = MOVE_DOWN;
            end
        end else begin
            if (phs_q[basePhase] && phs_q[nextPhase]) begin
                move = MOVE_HOLD;
            end else if (phs_q[nextPhase]) begin
                move = MOVE_UP;
            end else if (phs_q[basePhase]) begin
                move = MOVE_DOWN;
            end
        end
    end

    // Next-state logic. The countdown expiry is evaluated before the access
    // decode so that a motor-on access in the expiry cycle overrides it.
    always_comb begin
        phs_d       = phs_q;
        motorOn_d   = motorOn_q;
        countRun_d  = countRun_q;
        count_d     = count_q;
        driveSel_d  = driveSel_q;
        q6_d        = q6_q;
        q7_d        = q7_q;
        stepCnt_d   = stepCnt_q;
        halfTrack_d = halfTrack_q;
        step_d      = 1'b0;
        bump_d      = 1'b0;

        if (countRun_q) begin
            if (count_q == '0) begin
                motorOn_d  = 1'b0;
                countRun_d = 1'b0;
            end else begin
                count_d = count_q - 1'b1;
            end
        end

        if (!motorOn_q || stepTick) begin
            stepCnt_d = '0;
        end else begin
            stepCnt_d = stepCnt_q + 1'b1;
        end

        if (stepTick) begin
            case (move)
                MOVE_UP: begin
                    if (halfTrack_q == H_MAX) begin
                        bump_d = 1'b1;
                    end else begin
                        halfTrack_d = halfTrack_q + 7'd1;
                        step_d      = 1'b1;
                    end
                end
                MOVE_DOWN: begin
                    if (halfTrack_q == 7'd0) begin
                        bump_d = 1'b1;
                    end else begin
                        halfTrack_d = halfTrack_q - 7'd1;
                        step_d      = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        if (io_sel) begin
            case (sw)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    phs_d[sw[1:0]] = val;
                end
                3'd4: begin
                    if (val) begin
                        motorOn_d  = 1'b1;
                        countRun_d = 1'b0;
                        count_d    = '0;
                    end else if (motorOn_q && !countRun_q) begin
                        count_d    = OFF_LOAD;
                        countRun_d = 1'b1;
                    end
                end
                3'd5: driveSel_d = val;
                3'd6: q6_d       = val;
                default: q7_d    = val;
            endcase
        end
    end

    // State registers; reset abandons any countdown or pending step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phs_q       <= '0;
            motorOn_q   <= 1'b0;
            countRun_q  <= 1'b0;
            count_q     <= '0;
            driveSel_q  <= 1'b0;
            q6_q        <= 1'b0;
            q7_q        <= 1'b0;
            stepCnt_q   <= '0;
            halfTrack_q <= '0;
            step_q      <= 1'b0;
            bump_q      <= 1'b0;
        end else begin
            phs_q       <= phs_d;
            motorOn_q   <= motorOn_d;
            countRun_q  <= countRun_d;
            count_q     <= count_d;
            driveSel_q  <= driveSel_d;
            q6_q        <= q6_d;
            q7_q        <= q7_d;
            stepCnt_q   <= stepCnt_d;
            halfTrack_q <= halfTrack_d;
            step_q      <= step_d;
            bump_q      <= bump_d;
        end
    end

    assign phs        = phs_q;
    assign d1_active  = motorOn_q & ~driveSel_q;
    assign d2_active  = motorOn_q & driveSel_q;
    assign q6         = q6_q;
    assign q7         = q7_q;
    assign half_track = halfTrack_q;
    assign track      = halfTrack_q[6:1];
    assign step       = step_q;
    assign bump       = bump_q;

endmodule
